icache_resp: RTL and testbench

ICACHE_RESP -- requirements
Module: icache_resp

---
 rtl/icache_resp.sv | 188 ++++++++++++++++++
 tb/tb_icache_resp.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_resp.sv
// icache_resp: direct-mapped instruction cache with zero-cycle hits and a word-by-word line fill.
// Optional hit/miss statistics counters are built only when ICACHE_STATS_EN is defined.
module icache_resp #(
    parameter int NUM_LINES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    input  logic [31:0] i_req_addr,
    input  logic        i_flush,
    output logic [31:0] o_inst,
    output logic        o_inst_valid,
    output logic        o_stall,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic [31:0] o_hit_cnt,
    output logic [31:0] o_miss_cnt
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FILL       = 2'd1,
        FLUSH_PEND = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [NUM_LINES-1:0] valid_r;
    logic [TAG_W-1:0]     tag_r  [NUM_LINES];
    logic [31:0]          data_r [NUM_LINES][4];
    logic [27:0]          line_r;
    logic [1:0]           word_cnt_r;
    logic                 flush_rec_r;

    logic [IDX_W-1:0]     req_idx_s;
    logic [IDX_W-1:0]     fill_idx_s;
    logic [TAG_W-1:0]     req_tag_s;
    logic [TAG_W-1:0]     fill_tag_s;
    logic [1:0]           req_off_s;
    logic                 hit_s;
    logic                 idle_hit_s;
    logic                 idle_miss_s;
    logic                 fill_ack_s;
    logic                 fill_last_s;
    logic                 flush_seen_s;
    logic                 unused_s;

    assign req_off_s    = i_req_addr[3:2];
    assign req_idx_s    = i_req_addr[4 +: IDX_W];
    assign req_tag_s    = i_req_addr[31 -: TAG_W];
    assign fill_idx_s   = line_r[IDX_W-1:0];
    assign fill_tag_s   = line_r[27 -: TAG_W];
    assign unused_s     = ^i_req_addr[1:0];

    assign hit_s        = i_req_valid & valid_r[req_idx_s] & (tag_r[req_idx_s] == req_tag_s);
    assign idle_hit_s   = (state_r == IDLE) & hit_s;
    assign idle_miss_s  = (state_r == IDLE) & i_req_valid & ~hit_s;
    assign fill_ack_s   = (state_r == FILL) & i_mem_ack;
    assign fill_last_s  = fill_ack_s & (word_cnt_r == 2'd3);
    // A flush raised on the final ack still counts: the line must not become valid.
    assign flush_seen_s = flush_rec_r | i_flush;

    // Next-state and output decode.
    always_comb begin
        state_s      = state_r;
        o_inst       = 32'd0;
        o_inst_valid = 1'b0;
        o_stall      = 1'b0;
        o_mem_req    = 1'b0;
        o_mem_addr   = 32'd0;
        case (state_r)
            IDLE: begin
                if (idle_hit_s) begin
                    o_inst       = data_r[req_idx_s][req_off_s];
                    o_inst_valid = 1'b1;
                end else if (i_req_valid) begin
                    o_stall = 1'b1;
                    state_s = FILL;
                end else begin
                    state_s = IDLE;
                end
            end
            FILL: begin
                o_stall    = 1'b1;
                o_mem_req  = 1'b1;
                o_mem_addr = {line_r, word_cnt_r, 2'b00};
                if (fill_last_s) begin
                    if (flush_seen_s) begin
                        state_s = FLUSH_PEND;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = FILL;
                end
            end
            FLUSH_PEND: begin
                o_stall = 1'b1;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Miss line address, fill word counter and flush record.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            line_r      <= 28'd0;
            word_cnt_r  <= 2'd0;
            flush_rec_r <= 1'b0;
        end else begin
            if (idle_miss_s) begin
                line_r <= i_req_addr[31:4];
            end
            if (fill_ack_s) begin
                word_cnt_r <= word_cnt_r + 2'd1;
            end
            if ((state_r == FILL) && !fill_last_s) begin
                flush_rec_r <= flush_seen_s;
            end else begin
                flush_rec_r <= 1'b0;
            end
        end
    end

    // Valid bits: bulk clear on flush, set when an unflushed fill completes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_r <= {NUM_LINES{1'b0}};
        end else if (((state_r == IDLE) && i_flush) || (state_r == FLUSH_PEND)) begin
            valid_r <= {NUM_LINES{1'b0}};
        end else if (fill_last_s && !flush_seen_s) begin
            valid_r[fill_idx_s] <= 1'b1;
        end
    end

    // Data and tag arrays are qualified by valid, so they carry no reset.
    always_ff @(posedge i_clk) begin
        if (fill_ack_s) begin
            data_r[fill_idx_s][word_cnt_r] <= i_mem_rdata;
        end
        if (fill_last_s) begin
            tag_r[fill_idx_s] <= fill_tag_s;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_r;
    logic [31:0] miss_cnt_r;

    // Statistics counters, wrapping at 2^32.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hit_cnt_r  <= 32'd0;
            miss_cnt_r <= 32'd0;
        end else begin
            if (idle_hit_s) begin
                hit_cnt_r <= hit_cnt_r + 32'd1;
            end
            if (idle_miss_s) begin
                miss_cnt_r <= miss_cnt_r + 32'd1;
            end
        end
    end

    assign o_hit_cnt  = hit_cnt_r;
    assign o_miss_cnt = miss_cnt_r;
`else
    assign o_hit_cnt  = 32'd0;
    assign o_miss_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_icache_resp.sv
// Self-checking bench for icache_resp: directed scenarios plus randomized fetch traffic
// compared against a line-level model of the cache and a synthetic backing memory.
module tb_icache_resp;
    localparam int NL = 16;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        flush;
    logic [31:0] inst;
    logic        inst_valid;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int tests_run;
    int tests_failed;

    bit          m_valid [NL];
    int unsigned m_tag   [NL];
    int unsigned m_hits;
    int unsigned m_misses;

    icache_resp #(.NUM_LINES(NL)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .i_req_addr   (req_addr),
        .i_flush      (flush),
        .o_inst       (inst),
        .o_inst_valid (inst_valid),
        .o_stall      (stall),
        .o_mem_req    (mem_req),
        .o_mem_addr   (mem_addr),
        .i_mem_ack    (mem_ack),
        .i_mem_rdata  (mem_rdata),
        .o_hit_cnt    (hit_cnt),
        .o_miss_cnt   (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mem(input logic ack);
        mem_ack   = ack;
        mem_rdata = mem_fn(mem_addr);
    endtask

    task automatic model_clear();
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    endtask

    task automatic check_counters(input string tag);
`ifdef ICACHE_STATS_EN
        check_eq({tag, "_hits"}, hit_cnt, m_hits);
        check_eq({tag, "_misses"}, miss_cnt, m_misses);
`else
        check_eq({tag, "_hits"}, hit_cnt, 32'd0);
        check_eq({tag, "_misses"}, miss_cnt, 32'd0);
`endif
    endtask

    task automatic idle_check();
        req_valid = 1'b0;
        flush     = 1'b0;
        set_mem(1'($urandom_range(0, 1)));
        #1;
        check_eq("idle_stall", {31'd0, stall}, 32'd0);
        check_eq("idle_ivalid", {31'd0, inst_valid}, 32'd0);
        check_eq("idle_inst", inst, 32'd0);
        check_eq("idle_memreq", {31'd0, mem_req}, 32'd0);
        tick();
    endtask

    // One fetch: hit, or miss + full fill + replay. flush_ack / rst_ack select the ack index (-1 = none).
    task automatic do_fetch(input logic [31:0] addr, input int flush_ack, input int rst_ack,
                            input bit rand_ack, output int stall_cycles);
        int unsigned idx = (addr / 16) % NL;
        int unsigned tg  = addr / (16 * NL);
        logic [31:0] base = addr & 32'hFFFF_FFF0;
        bit exp_hit = m_valid[idx] && (m_tag[idx] == tg);
        bit flushed = 1'b0;
        int k = 0;
        int guard = 0;
        logic ack;
        req_valid = 1'b1;
        req_addr  = addr;
        flush     = 1'b0;
        set_mem(1'b0);
        #1;
        check_eq("req_stall", {31'd0, stall}, {31'd0, !exp_hit});
        check_eq("req_ivalid", {31'd0, inst_valid}, {31'd0, exp_hit});
        check_eq("req_inst", inst, exp_hit ? mem_fn(addr & 32'hFFFF_FFFC) : 32'd0);
        stall_cycles = exp_hit ? 0 : 1;
        if (exp_hit) m_hits++;
        else m_misses++;
        tick();
        if (exp_hit) return;
        while (k < 4 && guard < 200) begin
            req_addr = $urandom;
            ack = rand_ack ? 1'($urandom_range(0, 1)) : 1'b1;
            flush = ack && (k == flush_ack);
            if (flush) flushed = 1'b1;
            set_mem(ack);
            #1;
            check_eq("fill_stall", {31'd0, stall}, 32'd1);
            check_eq("fill_memreq", {31'd0, mem_req}, 32'd1);
            check_eq("fill_addr", mem_addr, base + 32'(4 * k));
            check_eq("fill_ivalid", {31'd0, inst_valid}, 32'd0);
            stall_cycles++;
            if (ack) k++;
            guard++;
            tick();
            if (rst_ack >= 0 && k == rst_ack) begin
                rst = 1'b1;
                flush = 1'b0;
                set_mem(1'b1);
                tick();
                rst = 1'b0;
                req_valid = 1'b0;
                set_mem(1'b0);
                model_clear();
                m_hits = 0;
                m_misses = 0;
                #1;
                check_eq("rst_memreq", {31'd0, mem_req}, 32'd0);
                check_eq("rst_stall", {31'd0, stall}, 32'd0);
                check_counters("rst_cnt");
                tick();
                return;
            end
        end
        check_eq("fill_acks", k, 4);
        flush = 1'b0;
        set_mem(1'b0);
        req_addr = addr;
        if (flushed) begin
            #1;
            check_eq("fpend_stall", {31'd0, stall}, 32'd1);
            check_eq("fpend_memreq", {31'd0, mem_req}, 32'd0);
            check_eq("fpend_ivalid", {31'd0, inst_valid}, 32'd0);
            stall_cycles++;
            model_clear();
            tick();
        end else begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            #1;
            check_eq("replay_ivalid", {31'd0, inst_valid}, 32'd1);
            check_eq("replay_stall", {31'd0, stall}, 32'd0);
            check_eq("replay_inst", inst, mem_fn(addr & 32'hFFFF_FFFC));
            m_hits++;
            tick();
        end
    endtask

    task automatic flush_hit(input logic [31:0] addr);
        req_valid = 1'b1;
        req_addr  = addr;
        flush     = 1'b1;
        set_mem(1'b0);
        #1;
        check_eq("fhit_ivalid", {31'd0, inst_valid}, 32'd1);
        check_eq("fhit_inst", inst, mem_fn(addr & 32'hFFFF_FFFC));
        m_hits++;
        tick();
        flush = 1'b0;
        model_clear();
    endtask

    initial begin
        int sc;
        int unsigned tags [4];
        logic [31:0] a;
        tags[0] = 0; tags[1] = 1; tags[2] = 24'hABCDE; tags[3] = 24'hFFFFFF;
        tests_run = 0;
        tests_failed = 0;
        m_hits = 0;
        m_misses = 0;
        model_clear();
        rst = 1'b1;
        req_valid = 1'b0;
        req_addr = 32'd0;
        flush = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = 32'd0;
        tick();
        tick();
        rst = 1'b0;
        idle_check();
        check_counters("reset_cnt");

        do_fetch(32'h0000_0004, -1, -1, 1'b0, sc);
        check_eq("miss_penalty", sc, 5);
        do_fetch(32'h0000_000C, -1, -1, 1'b0, sc);
        check_eq("hit_stall_cycles", sc, 0);
        do_fetch(32'h0000_0104, -1, -1, 1'b0, sc);
        do_fetch(32'h0000_0004, -1, -1, 1'b0, sc);
        check_eq("evict_refill", sc, 5);

        do_fetch(32'h0000_0020, 1, -1, 1'b0, sc);
        check_eq("flush_fill_cycles", sc, 6);
        do_fetch(32'h0000_0020, -1, -1, 1'b0, sc);
        check_eq("after_flush_miss", sc, 5);
        flush_hit(32'h0000_0028);
        do_fetch(32'h0000_0028, -1, -1, 1'b0, sc);
        check_eq("idle_flush_miss", sc, 5);
        idle_check();

        do_fetch(32'h0000_0030, -1, 2, 1'b0, sc);
        do_fetch(32'h0000_0030, -1, -1, 1'b0, sc);
        check_eq("post_rst_miss", sc, 5);
        do_fetch(32'h0000_0034, -1, -1, 1'b0, sc);
        do_fetch(32'h0000_0038, -1, -1, 1'b0, sc);
        check_counters("stats_1m3h");

        for (int it = 0; it < 300; it++) begin
            a = (32'(tags[$urandom_range(0, 3)]) << 8) | (32'($urandom_range(0, 15)) << 4)
                | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0: idle_check();
                1: begin
                    if (m_valid[(a / 16) % NL] && m_tag[(a / 16) % NL] == a / (16 * NL)) flush_hit(a);
                    else idle_check();
                end
                2: do_fetch(a, $urandom_range(0, 3), -1, 1'b1, sc);
                default: do_fetch(a, -1, -1, 1'b1, sc);
            endcase
        end
        check_counters("rand_cnt");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
